// File: rtl/isp_pkg.sv
// Shared types for the Bayer stream transmitter.
// Holds the FSM encoding and the GBRG colour-phase helper.
package isp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ACTIVE,
    GAP,
    FLUSH
  } tx_state_t;

  typedef enum logic [1:0] {
    BAYER_R,
    BAYER_G,
    BAYER_B
  } bayer_color_t;

  function automatic bayer_color_t bayer_color(
    input logic row_lsb,
    input logic col_lsb
  );
    unique case ({row_lsb, col_lsb})
      2'b00:   bayer_color = BAYER_G;
      2'b01:   bayer_color = BAYER_B;
      2'b10:   bayer_color = BAYER_R;
      default: bayer_color = BAYER_G;
    endcase
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter for one raster frame.
// Wraps to (0,0) after the last pixel of the frame.
module raster_counter #(
  parameter int width  = 320,
  parameter int height = 240
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adv,
  input  logic                      clr,
  output logic [$clog2(width)-1:0]  col,
  output logic [$clog2(height)-1:0] row,
  output logic                      endOfRow,
  output logic                      endOfFrame
);

  localparam int CW = $clog2(width);
  localparam int RW = $clog2(height);

  assign endOfRow   = (col == CW'(width - 1));
  assign endOfFrame = endOfRow && (row == RW'(height - 1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (endOfRow) begin
        col <= '0;
        row <= endOfFrame ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bayer_stream_tx.sv
// RGB-to-GBRG raw stream source with lead-in, row gaps and frame flush.
// Define BAYER_TX_FLUSH_EN to enable the end-of-frame FLUSH state.
module bayer_stream_tx
  import isp_pkg::*;
#(
  parameter int width      = 320,
  parameter int height     = 240,
  parameter int leadCycles = 32,
  parameter int rowGap     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic       iValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic       oReady,
  input  logic       iDone,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oBusy
);

  localparam int MAXC =
    (leadCycles > rowGap) ? leadCycles : rowGap;
  localparam int CW = $clog2(MAXC + 1);

`ifdef BAYER_TX_FLUSH_EN
  localparam tx_state_t LAST_NEXT = FLUSH;
`else
  localparam tx_state_t LAST_NEXT = IDLE;
  logic unused_done;
  assign unused_done = iDone;
`endif

  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [$clog2(width)-1:0]  col;
  logic [$clog2(height)-1:0] row;
  logic eor, eof, adv, clr;
  logic nf_n, ov_n;
  logic [7:0] od_n, pix;

  raster_counter #(
    .width (width),
    .height(height)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .clr       (clr),
    .col       (col),
    .row       (row),
    .endOfRow  (eor),
    .endOfFrame(eof)
  );

  always_comb begin
    case (bayer_color(row[0], col[0]))
      BAYER_R: pix = iR;
      BAYER_B: pix = iB;
      default: pix = iG;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    adv     = 1'b0;
    clr     = 1'b0;
    nf_n    = 1'b0;
    ov_n    = 1'b0;
    od_n    = 8'd0;
    unique case (state)
      IDLE: begin
        clr   = 1'b1;
        cnt_n = '0;
        if (iStart) begin
          state_n = LEAD;
          nf_n    = 1'b1;
        end
      end
      LEAD: begin
        if (cnt == CW'(leadCycles - 1)) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (iValid) begin
          adv  = 1'b1;
          ov_n = 1'b1;
          od_n = pix;
          if (eor)
            state_n = eof ? LAST_NEXT : GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(rowGap - 1)) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef BAYER_TX_FLUSH_EN
      FLUSH: begin
        if (iDone)
          state_n = IDLE;
        else
          ov_n = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state so ready tracks state only
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      newFrame <= 1'b0;
      oValid   <= 1'b0;
      oData    <= 8'd0;
      oReady   <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      newFrame <= nf_n;
      oValid   <= ov_n;
      oData    <= od_n;
      oReady   <= (state_n == ACTIVE);
      oBusy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Randomized self-checking bench for bayer_stream_tx.
// Two instances: a 4x2 frame and an 8x128 frame.
module tb_bayer_stream_tx;

  localparam int LEAD = 32;
  localparam int GAP  = 16;
  localparam int AW   = 4;
  localparam int AH   = 2;
  localparam int BW   = 8;
  localparam int BH   = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st_a = 1'b0;
  logic st_b = 1'b0;
  logic i_valid = 1'b0;
  logic i_done = 1'b0;
  logic [7:0] i_r = 8'd0;
  logic [7:0] i_g = 8'd0;
  logic [7:0] i_b = 8'd0;
  logic sel = 1'b0;

  logic a_ready, a_nf, a_ov, a_busy;
  logic b_ready, b_nf, b_ov, b_busy;
  logic [7:0] a_od, b_od;

  logic cur_ready, cur_nf, cur_ov, cur_busy;
  logic [7:0] cur_od;

  int total = 0;
  int bad = 0;

  logic [7:0] pat [8] = '{8'd1, 8'd12, 8'd21, 8'd32,
                          8'd40, 8'd51, 8'd60, 8'd71};

  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_nf    = sel ? b_nf    : a_nf;
  assign cur_ov    = sel ? b_ov    : a_ov;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_od    = sel ? b_od    : a_od;

  always #5 clk = ~clk;

  bayer_stream_tx #(
    .width(AW), .height(AH),
    .leadCycles(LEAD), .rowGap(GAP)
  ) dut_a (
    .clk(clk), .reset(reset), .iStart(st_a),
    .iValid(i_valid), .iR(i_r), .iG(i_g), .iB(i_b),
    .oReady(a_ready), .iDone(i_done), .newFrame(a_nf),
    .oValid(a_ov), .oData(a_od), .oBusy(a_busy)
  );

  bayer_stream_tx #(
    .width(BW), .height(BH),
    .leadCycles(LEAD), .rowGap(GAP)
  ) dut_b (
    .clk(clk), .reset(reset), .iStart(st_b),
    .iValid(i_valid), .iR(i_r), .iG(i_g), .iB(i_b),
    .oReady(b_ready), .iDone(i_done), .newFrame(b_nf),
    .oValid(b_ov), .oData(b_od), .oBusy(b_busy)
  );

  function automatic logic [7:0] bayer_ref(
    input int k, input int w,
    input logic [7:0] r, input logic [7:0] g,
    input logic [7:0] b
  );
    int row, col;
    row = k / w;
    col = k % w;
    if (row % 2 == 0)
      return (col % 2 == 0) ? g : b;
    else
      return (col % 2 == 0) ? r : g;
  endfunction

  task automatic run_frame(
    input bit use_b, input int mode, input int abort_k
  );
    int w, h, k, cyc, gap_cnt, drop_left;
    bit counting, dropped, acc, rdy;
    logic [7:0] exp_d, vr, vg, vb;
    w = use_b ? BW : AW;
    h = use_b ? BH : AH;
    sel = use_b;
    @(negedge clk);
    i_valid = 1'b0;
    i_done = 1'b0;
    if (use_b) st_b = 1'b1;
    else st_a = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cur_nf, cur_busy, cur_ov, cur_ready} !== 4'b1100)
      $display("FAIL start_pulse got=%b want=1100",
               {cur_nf, cur_busy, cur_ov, cur_ready});
    if ({cur_nf, cur_busy, cur_ov, cur_ready} !== 4'b1100)
      bad++;
    @(negedge clk);
    st_a = 1'b0;
    st_b = 1'b0;
    for (int i = 2; i <= LEAD; i++) begin
      @(posedge clk); #1;
      total++;
      if ({cur_nf, cur_ov, cur_ready, cur_busy} !== 4'b0001) begin
        bad++;
        $display("FAIL lead cyc=%0d got=%b want=0001", i,
                 {cur_nf, cur_ov, cur_ready, cur_busy});
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    total++;
    if ({cur_ov, cur_ready} !== 2'b01) begin
      bad++;
      $display("FAIL lead_end got=%b want=01", {cur_ov, cur_ready});
    end
    @(negedge clk);
    k = 0; cyc = 0; counting = 0; gap_cnt = 0;
    drop_left = 0; dropped = 0;
    while (k < w * h) begin
      cyc++;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL timeout got=%0d want=%0d pixels", k, w * h);
        break;
      end
      if (abort_k >= 0 && k == abort_k) begin
        reset = 1'b0;
        i_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cur_nf, cur_ov, cur_ready, cur_busy, cur_od} !== 12'd0) begin
          bad++;
          $display("FAIL abort_out got=%h want=0",
                   {cur_nf, cur_ov, cur_ready, cur_busy, cur_od});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          total++;
          if ({cur_nf, cur_busy, cur_ov} !== 3'b000) begin
            bad++;
            $display("FAIL post_abort got=%b want=000",
                     {cur_nf, cur_busy, cur_ov});
          end
        end
        @(negedge clk);
        return;
      end
      if (mode == 1 && !dropped && k == w + 1) begin
        drop_left = 3;
        dropped = 1;
      end
      rdy = cur_ready;
      if (mode == 2) begin
        vr = 8'(10 * k);
        vg = 8'(10 * k + 1);
        vb = 8'(10 * k + 2);
      end else begin
        vr = 8'($urandom);
        vg = 8'($urandom);
        vb = 8'($urandom);
      end
      if (drop_left > 0) begin
        i_valid = 1'b0;
        drop_left--;
      end else if (mode == 1) begin
        i_valid = ($urandom_range(0, 4) != 0);
      end else begin
        i_valid = 1'b1;
      end
      i_r = vr; i_g = vg; i_b = vb;
      i_done = (mode == 0) ? 1'($urandom) : 1'b0;
      if (mode != 1 && k == 1) begin
        if (use_b) st_b = 1'b1;
        else st_a = 1'b1;
      end
      acc = rdy && i_valid;
      if (counting) begin
        if (!rdy) gap_cnt++;
        else begin
          total++;
          if (gap_cnt != GAP) begin
            bad++;
            $display("FAIL gap_len got=%0d want=%0d", gap_cnt, GAP);
          end
          counting = 0;
        end
      end else begin
        total++;
        if (rdy !== 1'b1) begin
          bad++;
          $display("FAIL ready_row k=%0d got=%b want=1", k, rdy);
        end
      end
      exp_d = (mode == 2) ? pat[k % 8] : bayer_ref(k, w, vr, vg, vb);
      @(posedge clk); #1;
      st_a = 1'b0;
      st_b = 1'b0;
      total++;
      if (acc) begin
        if ({cur_ov, cur_od} !== {1'b1, exp_d}) begin
          bad++;
          $display("FAIL pixel k=%0d got=%b/%0d want=1/%0d",
                   k, cur_ov, cur_od, exp_d);
        end
        if (k % w == w - 1 && k != w * h - 1) begin
          counting = 1;
          gap_cnt = 0;
        end
        k++;
      end else if (cur_ov !== 1'b0) begin
        bad++;
        $display("FAIL bubble k=%0d got=%b want=0", k, cur_ov);
      end
      total++;
      if (cur_nf !== 1'b0) begin
        bad++;
        $display("FAIL stray_newframe k=%0d got=%b want=0", k, cur_nf);
      end
      @(negedge clk);
    end
    total++;
    if (k != w * h) begin
      bad++;
      $display("FAIL pixel_count got=%0d want=%0d", k, w * h);
    end
    i_valid = 1'b0;
    i_done = 1'b0;
`ifdef BAYER_TX_FLUSH_EN
    repeat ($urandom_range(2, 5)) begin
      @(posedge clk); #1;
      total++;
      if ({cur_ov, cur_od, cur_busy} !== {1'b1, 8'd0, 1'b1}) begin
        bad++;
        $display("FAIL flush got=%b/%0d/%b want=1/0/1",
                 cur_ov, cur_od, cur_busy);
      end
      @(negedge clk);
    end
    i_done = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cur_ov, cur_busy} !== 2'b00) begin
      bad++;
      $display("FAIL flush_exit got=%b want=00", {cur_ov, cur_busy});
    end
`else
    i_done = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cur_ov, cur_busy} !== 2'b00) begin
      bad++;
      $display("FAIL tail_idle got=%b want=00", {cur_ov, cur_busy});
    end
`endif
    @(negedge clk);
    i_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a_nf, a_ov, a_ready, a_busy, a_od} !== 12'd0) begin
      bad++;
      $display("FAIL reset_a got=%h want=0",
               {a_nf, a_ov, a_ready, a_busy, a_od});
    end
    total++;
    if ({b_nf, b_ov, b_ready, b_busy, b_od} !== 12'd0) begin
      bad++;
      $display("FAIL reset_b got=%h want=0",
               {b_nf, b_ov, b_ready, b_busy, b_od});
    end
    @(negedge clk);
    st_a = 1'b1;
    st_b = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_nf, a_busy, b_nf, b_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_wins got=%b want=0000",
               {a_nf, a_busy, b_nf, b_busy});
    end
    @(negedge clk);
    st_a = 1'b0;
    st_b = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if ({a_nf, a_busy, b_nf, b_busy} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_hold got=%b want=0000",
                 {a_nf, a_busy, b_nf, b_busy});
      end
    end
  endtask

  task automatic test_pattern;
    run_frame(1'b0, 2, -1);
  endtask

  task automatic test_bubbles;
    run_frame(1'b0, 1, -1);
    run_frame(1'b0, 1, -1);
  endtask

  task automatic test_full_frame;
    run_frame(1'b1, 0, -1);
  endtask

  task automatic test_abort_restart;
    run_frame(1'b1, 0, 100 * BW + 3);
    run_frame(1'b1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_bubbles();
    test_full_frame();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bayer_stream_tx.md
# bayer_stream_tx

- Hardware source for the raw Bayer pixel stream consumed by `processing`.
- Accepts full RGB pixels from a frame source and keeps one colour per pixel in GBRG order.
- Emits the `newFrame` pulse, the lead-in delay, inter-row blanking and the end-of-frame flush that the ISP input protocol requires.
- Sits between the camera/frame-buffer reader and the `processing` top.

## Interface

Parameters:

- `width`, 320, active pixels per row
- `height`, 240, active rows per frame
- `leadCycles`, 32, idle cycles between the `newFrame` pulse and the first pixel
- `rowGap`, 16, blanking cycles after each row (`oValid` low)

Ports:

- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-low; sampled on posedge `clk`
- `iStart`  in  1  one-cycle request to begin a frame; honoured only in IDLE
- `iValid`  in  1  source RGB pixel valid
- `iR`, `iG`, `iB`  in  8 each  source pixel, unsigned
- `oReady`  out  1  source handshake; a pixel transfers when `iValid && oReady`
- `iDone`  in  1  downstream frame-complete (`oDoneDemosaic`)
- `newFrame`  out  1  one-cycle frame-start pulse to the ISP
- `oValid`  out  1  raw pixel valid to the ISP
- `oData`  out  8  raw Bayer sample
- `oBusy`  out  1  high in every state except IDLE

## Operation

States:

- IDLE
  - Outputs low, counters cleared.
  - `iStart` -> LEAD, with `newFrame` = 1 for exactly one cycle.
- LEAD
  - Counts `leadCycles` cycles with `oValid` = 0, then -> ACTIVE.
- ACTIVE
  - `oReady` = 1.
  - Each accepted pixel produces one output pixel and advances `col`.
  - A cycle with `!iValid` inserts a bubble: `oValid` = 0, counters hold.
  - On acceptance with `col == width-1`:
    - `col` wraps to 0 and `row` increments.
    - If `row == height-1` -> FLUSH; otherwise -> GAP.
- GAP
  - `oReady` = 0, `oValid` = 0 for `rowGap` cycles, then -> ACTIVE.
- FLUSH
  - `oValid` = 1, `oData` = 0 every cycle until `iDone` is sampled high.
  - On `iDone`: `oValid` = 0 that cycle, -> IDLE.

Bayer selection, with `row`/`col` being those of the accepted pixel:

- even row, even col -> G
- even row, odd col -> B
- odd row, even col -> R
- odd row, odd col -> G

Counters:

- `col` has width `$clog2(width)`; `row` has width `$clog2(height)`.
- The gap/lead counter width is `$clog2(max(leadCycles,rowGap)+1)`.
- No arithmetic on pixel data; selection only.

Boundary conditions:

- `iStart` outside IDLE is ignored.
- `iDone` outside FLUSH is ignored.
- `reset` low in any state:
  - Next posedge: IDLE, all outputs 0, counters 0.
  - A partial frame is abandoned, with no `newFrame` until the next `iStart`.
- `iStart` and `reset` low in the same cycle: reset wins.

## Timing

- Reset values: `newFrame`, `oValid`, `oReady`, `oBusy` = 0; `oData` = 8'd0.
- All outputs are registered.
- `iStart` at cycle T -> `newFrame` high at T+1.
- First accepted pixel no earlier than T+1+`leadCycles`.
- Accepted pixel at cycle N -> `oValid`/`oData` at N+1 (latency 1).
- `oReady` is a function of state only; it never depends combinationally on `iValid`.
- Last pixel of a row accepted at N:
  - `oReady` = 0 from N+1 through N+`rowGap`.
  - First pixel of the next row is accepted no earlier than N+`rowGap`+1.
- Best-case frame, `iValid` always high:
  - 1 + `leadCycles` + `height`·`width` + (`height`−1)·`rowGap` cycles from `iStart` to the last pixel on `oData`, plus the flush.

## Configuration

- `BAYER_TX_FLUSH_EN` defined:
  - FLUSH state present, behaving as described above.
- `BAYER_TX_FLUSH_EN` undefined:
  - The last accepted pixel goes directly to IDLE.
  - `iDone` is unused.
  - `oValid` is low after the final pixel.

## Structure

- Package `isp_pkg`:
  - `tx_state_t` enum (IDLE, LEAD, ACTIVE, GAP, FLUSH).
  - `bayer_color_t` enum (BAYER_R, BAYER_G, BAYER_B).
  - Function `bayer_color(row_lsb, col_lsb)` returning the GBRG mapping.
- One sub-module, `raster_counter`:
  - Parameterised `width`/`height` col/row counter.
  - Inputs: advance enable, clear.
  - Outputs: `col`, `row`, `endOfRow`, `endOfFrame`.
  - Synchronous active-low reset.

## Test plan

- Reset then `iStart`:
  - `newFrame` high exactly one cycle.
  - `oValid` = 0 for 32 cycles.
  - First `oData` equals the G of pixel (0,0).
- Known 4×2 pattern with `width`=4, `height`=2 and pixels R=10·k, G=10·k+1, B=10·k+2: output sequence 1,12,21,32, then 16-cycle gap, then 40,51,60,71.
- Source drops `iValid` for 3 cycles mid-row: 3-cycle bubble on `oValid`, no pixel lost or duplicated, Bayer phase unchanged.
- Full 320×240 frame with `iValid` always high: 76800 `oValid` pixels before flush; each row separated by exactly 16 low cycles.
- `BAYER_TX_FLUSH_EN` set: after the last pixel, `oData` = 0 with `oValid` = 1 until `iDone` pulses, then `oValid` = 0 and IDLE. Unset: `oValid` = 0 right after the last pixel.
- `reset` low mid-row 100:
  - Outputs are 0 next cycle.
  - A subsequent `iStart` restarts at (0,0) with a fresh `newFrame`.
